// File: rtl/addsub_seq_if.sv
// Operand/result bus for the sequential add/subtract unit.
//
// Handshake rules (both directions):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - The producer keeps its payload stable while valid=1 and ready=0.
//   - ready may depend on state only; it never waits on valid.
//   Input side:  in_valid/in_ready carry A, B and select into the unit.
//   Output side: out_valid/out_ready carry Result and the flags out of the unit.
interface addsub_seq_if #(
   parameter int WIDTH = 64
) ();

   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             select;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Result;
   logic             out_valid;
   logic             out_ready;
   logic             flag_c;
   logic             flag_v;
   logic             flag_z;
   logic             flag_n;

   // Operand source and result consumer side
   modport master (
      output A, B, select, in_valid, out_ready,
      input  in_ready, Result, out_valid, flag_c, flag_v, flag_z, flag_n
   );

   // Arithmetic unit side
   modport slave (
      input  A, B, select, in_valid, out_ready,
      output in_ready, Result, out_valid, flag_c, flag_v, flag_z, flag_n
   );

endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle integer add/subtract unit.
// Operands are consumed CHUNK bits per clock, least significant slice first,
// with the carry between slices held in a register. One operation in flight.
// Subtraction is A + ~B + 1: B is inverted at accept and the carry starts at 1.
// Optional feature: define ADDSUB_SEQ_SATURATE_EN to clamp signed overflow to
// the signed limit in the direction of A's sign (flag_c still reports the raw
// carry, flag_z/flag_n describe the clamped Result).
// state_dbg exposes the FSM state: 0 = IDLE, 1 = BUSY, 2 = DONE.
module addsub_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   addsub_seq_if.slave bus,
   output logic [1:0]  state_dbg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int MSB    = WIDTH - 1;

   if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;        // already inverted for subtract
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] result_q;
   logic             flag_c_q;
   logic             flag_v_q;
   logic             flag_z_q;
   logic             flag_n_q;

   logic             accept;
   logic             last;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_c;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] res_final;
   logic             raw_v;

   assign accept = bus.in_valid && (state_q == IDLE);
   assign last   = (k_q == KW'(NCHUNK - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = BUSY;
         BUSY:    if (last)          state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Slice selection, one slice of addition, and the Result with this slice merged in
   always_comb begin
      a_sl     = '0;
      b_sl     = '0;
      res_next = result_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            a_sl = a_q[i*CHUNK +: CHUNK];
            b_sl = b_q[i*CHUNK +: CHUNK];
         end
      end
      {chunk_c, chunk_s} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            res_next[i*CHUNK +: CHUNK] = chunk_s;
         end
      end
   end

   // Overflow detection and, when enabled, clamping on the final slice
   always_comb begin
      raw_v = (a_q[MSB] == b_q[MSB]) && (res_next[MSB] != a_q[MSB]);
`ifdef ADDSUB_SEQ_SATURATE_EN
      if (raw_v) begin
         res_final = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res_final = res_next;
      end
`else
      res_final = res_next;
`endif
   end

   // Operand capture, per-slice progress, and Result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         result_q <= '0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= bus.A;
                  b_q     <= bus.select ? ~bus.B : bus.B;
                  carry_q <= bus.select;
                  k_q     <= '0;
               end
            end
            BUSY: begin
               carry_q <= chunk_c;
               if (last) begin
                  k_q      <= '0;
                  result_q <= res_final;
                  flag_c_q <= chunk_c;
                  flag_v_q <= raw_v;
                  flag_z_q <= (res_final == '0);
                  flag_n_q <= res_final[MSB];
               end else begin
                  k_q      <= k_q + 1'b1;
                  result_q <= res_next;
               end
            end
            default: begin
               // DONE holds everything stable until the consumer takes it
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.Result    = result_q;
   assign bus.flag_c    = flag_c_q;
   assign bus.flag_v    = flag_v_q;
   assign bus.flag_z    = flag_z_q;
   assign bus.flag_n    = flag_n_q;
   assign state_dbg     = state_q;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle integer add/subtract unit; next generation of the team's combinational 64-bit adder.
- Processes operands in CHUNK-bit slices, one slice per clock, with a registered carry between slices.
- Uses valid/ready handshakes on input and output.
- Produces carry, overflow, zero and negative flags.
- Sits between the ALU operand latch and the result writeback mux.

Parameters:
WIDTH, 64, operand and result width in bits
CHUNK, 16, bits processed per cycle; WIDTH % CHUNK must be 0, otherwise $error at elaboration
NCHUNK, WIDTH/CHUNK, derived localparam; cycles per operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand A, sampled at accept
B  input  WIDTH  operand B, sampled at accept
select  input  1  0 = A+B, 1 = A-B; sampled at accept
in_valid  input  1  operands valid
in_ready  output  1  unit can accept an operation
Result  output  WIDTH  sum/difference, registered
out_valid  output  1  Result and flags valid
out_ready  input  1  consumer accepts result
flag_c  output  1  carry out of MSB; for subtract 1 = no borrow
flag_v  output  1  signed overflow
flag_z  output  1  Result == 0
flag_n  output  1  Result[WIDTH-1]

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; Result=0; all flags 0; out_valid=0; internal carry and chunk index cleared.
- in_ready: combinational, 1 exactly when state==IDLE. in_ready=1 while rst_n is low and after release.
- Accept condition: in_valid && in_ready at a rising edge.
  - Latch A.
  - Latch B' = select ? ~B : B.
  - Latch carry = select.
  - Set index k=0; go to BUSY.
- State machine:
  - IDLE -> BUSY on accept.
  - BUSY: each cycle compute {c, s} = A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry.
    - Write s to Result[k*CHUNK +: CHUNK]; carry <= c; k <= k+1.
    - On k==NCHUNK-1: write flags and go to DONE.
  - DONE: out_valid=1. Result and flags are held stable while out_ready=0.
  - DONE -> IDLE on out_ready=1; out_valid drops the next cycle.
- Timing: out_valid rises exactly NCHUNK cycles after the accept edge (64/16 -> 4 cycles). Minimum initiation interval is NCHUNK+2 cycles; there is no overlap of operations.
- Flag definitions:
  - flag_c = final carry.
  - flag_v = (A[MSB]==B'[MSB]) && (Result[MSB]!=A[MSB]).
  - flag_z and flag_n are computed from the final Result.
- Flag timing: flags are updated only on the final BUSY cycle.
  - During BUSY they hold the previous operation's values.
  - Result slices update progressively during BUSY; consumers use Result only when out_valid=1.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent except through flags.
- Input side during BUSY/DONE: in_valid is ignored, with no capture and no error; new operands are not sampled until IDLE.
- Reset mid-operation: async clear of everything. The in-flight operation is discarded with no partial out_valid pulse.
- out_ready may be held high in advance: DONE then lasts exactly one cycle.

Optional Feature:
- Macro: ADDSUB_SEQ_SATURATE_EN.
- When defined, on the final cycle with flag_v=1, Result is replaced by the signed limit:
  - A[MSB]=0 -> 0111..1.
  - A[MSB]=1 -> 1000..0.
- flag_v still reports 1. flag_z and flag_n reflect the saturated Result. flag_c reports the raw carry.
- When undefined: wrap-around result, no extra logic.

Test Plan:
- WIDTH=64, CHUNK=16: A=5, B=3, select=0 -> out_valid 4 cycles after accept, Result=0x0000000000000008, c=v=z=n=0.
- A=0xFFFFFFFFFFFFFFFF, B=1, add -> Result=0, flag_c=1, flag_z=1, flag_v=0 (carry ripples across all 4 chunks).
- A=3, B=5, select=1 -> Result=0xFFFFFFFFFFFFFFFE, flag_c=0, flag_n=1. A=0x7FFFFFFFFFFFFFFF, B=1, add:
  - without macro -> Result=0x8000000000000000, flag_v=1, flag_n=1;
  - with ADDSUB_SEQ_SATURATE_EN -> Result=0x7FFFFFFFFFFFFFFF, flag_v=1, flag_n=0.
- Backpressure: A=0x123456789ABCDEF0, B=0x0FEDCBA987654321, add, out_ready=0 for 6 cycles:
  - Result=0x2222222222222211 held stable with out_valid=1 and in_ready=0;
  - a second in_valid pulse during this time is not captured;
  - out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 at the 2nd BUSY cycle -> immediately out_valid=0, Result=0, flags=0; after release in_ready=1, and the next op 5+3 gives 8.
